// File: rtl/alu_seg_display.sv
// alu_seg_display: glitch-filters the packed ALU status word and renders it on four
// active-low 7-seg digits, with a debounced hex/signed format toggle and an overflow blink.
module alu_seg_display #(
  parameter logic [15:0] DEB_CYC   = 16'd50000,
  parameter int unsigned BLINK_DIV = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] status_in,
  input  logic        btn_fmt,
  output logic [7:0]  seg0,
  output logic [7:0]  seg1,
  output logic [7:0]  seg2,
  output logic [7:0]  seg3,
  output logic        fmt_led
);

  localparam int unsigned SW = 16;
  localparam int unsigned CW = 10;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_C     = 8'h63;

  function automatic logic [7:0] digit_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0:    s = 8'h03;
      4'h1:    s = 8'h9F;
      4'h2:    s = 8'h25;
      4'h3:    s = 8'h0D;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h49;
      4'h6:    s = 8'h41;
      4'h7:    s = 8'h1F;
      4'h8:    s = 8'h01;
      4'h9:    s = 8'h09;
      4'hA:    s = 8'h11;
      4'hB:    s = 8'hC1;
      4'hC:    s = 8'h63;
      4'hD:    s = 8'h85;
      4'hE:    s = 8'h61;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  // cap holds only the live fields: {mode[2:0], flow, zero, carry, sum[3:0]}
  logic [SW-1:0]        s1;
  logic [CW-1:0]        cap;
  logic                 sync1;
  logic                 sync2;
  logic                 deb;
  logic [15:0]          deb_cnt;
  logic [BLINK_DIV-1:0] blink_cnt;
  logic                 deb_hit;

  // Status word filter: accept a sample only once it has been seen twice in a row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1  <= '0;
      cap <= '0;
    end else begin
      s1 <= status_in;
      if (s1 == status_in) cap <= {s1[15:13], s1[6:0]};
    end
  end

  assign deb_hit = (sync2 != deb) && (deb_cnt == DEB_CYC - 16'd1);

  // Button synchronizer, debouncer and format toggle on the debounced rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
      fmt_led <= 1'b0;
    end else begin
      sync1 <= btn_fmt;
      sync2 <= sync1;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_hit) begin
        deb_cnt <= '0;
        deb     <= sync2;
        if (sync2) fmt_led <= ~fmt_led;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_cnt <= '0;
    else        blink_cnt <= blink_cnt + BLINK_DIV'(1);
  end

  logic [3:0] sum;
  logic [3:0] mag;
  logic [7:0] seg0_nxt;
  logic [7:0] seg1_nxt;
  logic [7:0] seg2_nxt;
  logic [7:0] seg3_nxt;

  // Digit decode from the filtered word; -8 magnitude wraps to 4'h8 and shows as '8'
  always_comb begin
    sum      = cap[3:0];
    mag      = sum[3] ? 4'(~sum + 4'd1) : sum;
    seg0_nxt = digit_seg(sum);
    seg1_nxt = SEG_BLANK;
    if (fmt_led) begin
      seg0_nxt = digit_seg(mag);
      if (sum[3]) seg1_nxt = SEG_DASH;
    end
    if (cap[6] && blink_cnt[BLINK_DIV-1]) begin
      seg0_nxt = SEG_BLANK;
      seg1_nxt = SEG_BLANK;
    end
    seg2_nxt = digit_seg({1'b0, cap[9:7]});
    if (cap[6])      seg3_nxt = digit_seg(4'hF);
    else if (cap[4]) seg3_nxt = SEG_C;
    else if (cap[5]) seg3_nxt = digit_seg(4'h0);
    else             seg3_nxt = SEG_BLANK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg0 <= SEG_BLANK;
      seg1 <= SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
    end else begin
      seg0 <= seg0_nxt;
      seg1 <= seg1_nxt;
      seg2 <= seg2_nxt;
      seg3 <= seg3_nxt;
    end
  end

endmodule

// File: tb/tb_alu_seg_display.sv
// Bench for alu_seg_display: per-cycle comparison against a behavioural model plus
// directed scenarios with hand-computed literal digit codes.
module tb_alu_seg_display;

  localparam logic [15:0] DEB  = 16'd8;
  localparam int          DEBI = 8;
  localparam int unsigned BD   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] status_in = 16'h0000;
  logic        btn_fmt = 1'b0;
  logic [7:0]  seg0, seg1, seg2, seg3;
  logic        fmt_led;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_seg_display #(.DEB_CYC(DEB), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .status_in(status_in), .btn_fmt(btn_fmt),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .fmt_led(fmt_led)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: glyph table, run-length debounce, cycle count for blink phase
  logic [7:0] font [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                            8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  int          m_cyc = 0;
  logic [15:0] m_prev = '0;
  logic [15:0] m_cap = '0;
  logic        m_b1 = 1'b0, m_b2 = 1'b0, m_level = 1'b0, m_fmt = 1'b0;
  int          m_run = 0;
  logic [7:0]  e0 = 8'hFF, e1 = 8'hFF, e2 = 8'hFF, e3 = 8'hFF;
  logic        e_fmt = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0; m_prev = '0; m_cap = '0;
      m_b1 = 0; m_b2 = 0; m_level = 0; m_fmt = 0; m_run = 0;
      e0 = 8'hFF; e1 = 8'hFF; e2 = 8'hFF; e3 = 8'hFF; e_fmt = 0;
    end else begin
      int v;
      int sum;
      sum = int'(m_cap[3:0]);
      v = (sum >= 8) ? sum - 16 : sum;
      if (m_fmt) begin
        e0 = font[(v < 0) ? -v : v];
        e1 = (v < 0) ? 8'hFD : 8'hFF;
      end else begin
        e0 = font[sum];
        e1 = 8'hFF;
      end
      if (m_cap[6] && ((m_cyc % (1 << BD)) >= (1 << (BD - 1)))) begin
        e0 = 8'hFF;
        e1 = 8'hFF;
      end
      e2 = font[int'(m_cap[15:13])];
      e3 = m_cap[6] ? 8'h71 : m_cap[4] ? 8'h63 : m_cap[5] ? 8'h03 : 8'hFF;
      m_cyc++;
      if (status_in == m_prev) m_cap = m_prev;
      m_prev = status_in;
      if (m_b2 != m_level) begin
        m_run++;
        if (m_run == DEBI) begin
          m_level = m_b2;
          m_run = 0;
          if (m_b2) m_fmt = ~m_fmt;
        end
      end else begin
        m_run = 0;
      end
      m_b2 = m_b1;
      m_b1 = btn_fmt;
      e_fmt = m_fmt;
    end
  end

  // Continuous compare, sampled just after the falling edge
  initial begin
    forever begin
      @(negedge clk);
      #1;
      chk("cyc_seg0", seg0, e0);
      chk("cyc_seg1", seg1, e1);
      chk("cyc_seg2", seg2, e2);
      chk("cyc_seg3", seg3, e3);
      chk("cyc_fmt", {7'b0, fmt_led}, {7'b0, e_fmt});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic probe();
    #2;
  endtask

  initial begin
    logic [7:0] first_on;
    bit got_on, got_blank;

    // T1: reset values, then zero status after release
    #1 rst_n = 1'b0;
    cyc(2); probe();
    chk("t1_rst_seg0", seg0, 8'hFF);
    chk("t1_rst_seg3", seg3, 8'hFF);
    chk("t1_rst_fmt", {7'b0, fmt_led}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    cyc(3); probe();
    chk("t1_seg0", seg0, 8'h03);
    chk("t1_seg1", seg1, 8'hFF);
    chk("t1_seg2", seg2, 8'h03);
    chk("t1_seg3", seg3, 8'hFF);

    // T2: overflow with sum 9, hex format, blink visible over one period
    @(negedge clk) status_in = 16'h0069;
    cyc(3); probe();
    chk("t2_seg3", seg3, 8'h71);
    first_on = 8'hFF; got_on = 0; got_blank = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); probe();
      if (seg0 == 8'hFF) got_blank = 1;
      else if (!got_on) begin got_on = 1; first_on = seg0; end
    end
    chk("t2_seg0_digit", first_on, 8'h09);
    chk("t2_blank_seen", {7'b0, got_blank}, 8'h01);

    // T3: single-cycle glitch is filtered out
    @(negedge clk) status_in = 16'h0000;
    cyc(4);
    @(negedge clk) status_in = 16'h0005;
    @(negedge clk) status_in = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); probe();
      chk("t3_seg0_hold", seg0, 8'h03);
    end

    // T4: held press toggles once; short pulses are rejected
    @(negedge clk) btn_fmt = 1'b1;
    cyc(DEBI + 3);
    btn_fmt = 1'b0;
    probe();
    chk("t4_fmt_on", {7'b0, fmt_led}, 8'h01);
    @(negedge clk) status_in = 16'h000F;
    cyc(3); probe();
    chk("t4_seg1_minus", seg1, 8'hFD);
    chk("t4_seg0_one", seg0, 8'h9F);
    cyc(20);
    for (int p = 0; p < 2; p++) begin
      btn_fmt = 1'b1;
      cyc(5);
      btn_fmt = 1'b0;
      cyc(10);
    end
    probe();
    chk("t4_pulse_no_toggle", {7'b0, fmt_led}, 8'h01);
    @(negedge clk) status_in = 16'h0008;
    cyc(3); probe();
    chk("t4_minus8_seg0", seg0, 8'h01);
    chk("t4_minus8_seg1", seg1, 8'hFD);

    // T5: mode 1, carry beats zero
    @(negedge clk) status_in = 16'h2030;
    cyc(3); probe();
    chk("t5_seg3", seg3, 8'h63);
    chk("t5_seg2", seg2, 8'h9F);
    chk("t5_seg0", seg0, 8'h03);

    // T6: reset mid-debounce discards the press; a full period after reset is needed
    @(negedge clk) btn_fmt = 1'b1;
    cyc(DEBI - 2);
    rst_n = 1'b0;
    probe();
    chk("t6_rst_fmt", {7'b0, fmt_led}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    cyc(DEBI + 1); probe();
    chk("t6_fmt_still_0", {7'b0, fmt_led}, 8'h00);
    cyc(1); probe();
    chk("t6_fmt_toggled", {7'b0, fmt_led}, 8'h01);
    btn_fmt = 1'b0;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
